// File: rtl/alu_pkg.sv
// Shared types and sizing helpers for the nibble-serial subtractor.
package alu_pkg;

    localparam int unsigned NIB = 4;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    function automatic int unsigned idx_width(input int unsigned s);
        return (s <= 1) ? 1 : $clog2(s);
    endfunction

endpackage

// File: rtl/cla_sub_seq_if.sv
// Operand/result handshake bundle for cla_sub_seq.
interface cla_sub_seq_if #(
    parameter int unsigned N = 16
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         borrow;
    logic         ovf;
    logic         zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, ovf, zero
    );
endinterface

// File: rtl/sub4_slice.sv
// Combinational 4-bit carry-lookahead slice computing a + bn + cin.
module sub4_slice (
    input  logic [3:0] a,
    input  logic [3:0] bn,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & bn;
    assign p = a ^ bn;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];
endmodule

// File: rtl/cla_sub_seq.sv
// Nibble-serial a - b: one lookahead slice per clock, borrow chain held in carry_q.
module cla_sub_seq
    import alu_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic        clk,
    input  logic        rst,
    cla_sub_seq_if.slave bus
);
    localparam int unsigned S  = N / NIB;
    localparam int unsigned IW = idx_width(S);
    localparam logic [IW-1:0] IdxLast = IW'(S - 1);

    typedef logic [S-1:0][NIB-1:0] nibs_t;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    nibs_t           a_q, a_d, bn_q, bn_d, diff_q, diff_d;
    logic            carry_q, carry_d;
    logic            borrow_q, borrow_d;
    logic            ovf_q, ovf_d;
    logic            zero_q, zero_d;
    logic [NIB-1:0]  slice_sum;
    logic            slice_cout;

    sub4_slice u_slice (
        .a    (a_q[idx_q]),
        .bn   (bn_q[idx_q]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.in_valid) state_d = StRun;
            StRun:   if (idx_q == IdxLast) state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == StIdle) && !rst;
        bus.out_valid = (state_q == StDone);
    end

    always_comb begin
        idx_d    = idx_q;
        a_d      = a_q;
        bn_d     = bn_q;
        diff_d   = diff_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        if (state_q == StIdle && bus.in_valid) begin
            a_d     = bus.a;
            bn_d    = ~bus.b;
            carry_d = 1'b1;
            idx_d   = '0;
        end else if (state_q == StRun) begin
            diff_d[idx_q] = slice_sum;
            carry_d       = slice_cout;
            if (idx_q == IdxLast) begin
                idx_d    = '0;
                borrow_d = ~slice_cout;
                // bn holds ~b, so equal top bits mean the operand signs differ
                ovf_d    = (a_q[S-1][NIB-1] == bn_q[S-1][NIB-1])
                         && (slice_sum[NIB-1] != a_q[S-1][NIB-1]);
                zero_d   = (diff_d == '0);
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            a_q      <= '0;
            bn_q     <= '0;
            diff_q   <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            a_q      <= a_d;
            bn_q     <= bn_d;
            diff_q   <= diff_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.ovf    = ovf_q;
    assign bus.zero   = zero_q;
endmodule

// File: doc/cla_sub_seq.md
Name: cla_sub_seq

Overview:
- Nibble-serial N-bit subtractor: computes a - b one 4-bit lookahead slice per clock, with the borrow chain held in a register between slices.
- Counterpart to the combinational lookahead adder in the ALU datapath. It runs in the opposite arithmetic direction and trades latency for a single 4-bit slice of logic.
- Sits behind the ALU operand register and uses valid/ready handshakes on both input and output.

Parameters:
- N, 16, operand width. Must be a multiple of 4 and at least 4. Slice count S = N/4.

Ports:
- clk  input  1  Clock. All state changes on the rising edge.
- rst  input  1  Synchronous, active-high reset.
- in_valid  input  1  Operand pair presented.
- in_ready  output  1  Block can accept operands.
- a  input  N  Minuend.
- b  input  N  Subtrahend.
- out_valid  output  1  Result valid.
- out_ready  input  1  Consumer accepts result.
- diff  output  N  a - b, modulo 2^N.
- borrow  output  1  Unsigned underflow (a < b unsigned).
- ovf  output  1  Signed two's-complement overflow.
- zero  output  1  diff == 0.

Behaviour:
- Reset (rst high at a rising edge):
  - state = IDLE, slice index = 0, out_valid = 0.
  - diff, borrow, ovf and zero all = 0.
  - in_ready = 0 while rst is high.
  - Reset has priority over everything, including mid-RUN or mid-DONE; the in-flight operation is discarded.
- States: IDLE, RUN, DONE. in_ready = (state == IDLE) && !rst. out_valid = (state == DONE).
- IDLE:
  - On in_valid && in_ready, latch a, latch ~b, set carry = 1, set idx = 0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, one edge per slice:
  - Slice inputs are a[4*idx+3:4*idx], ~b[4*idx+3:4*idx] and carry.
  - Write the slice sum into diff[4*idx+3:4*idx]; carry <= slice carry-out; idx <= idx + 1.
  - On the edge that processes idx = S-1, go to DONE and register the flags:
    - borrow = ~final carry.
    - ovf = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]).
    - zero = (complete diff == 0), with the last nibble included.
- Latency: out_valid rises exactly S edges after the accepting edge (S = 4 for N = 16).
- DONE:
  - diff and all flags hold stable while out_valid = 1 && out_ready = 0. Back-pressure is unlimited.
  - On out_ready, go to IDLE at that edge and deassert out_valid.
  - No same-edge accept: in_ready is low in DONE. Throughput is one operation per S+2 cycles minimum.
- in_valid during RUN or DONE is ignored; the operands are not sampled. Latched operands are immune to input changes after acceptance.
- Between operations, diff and flags hold their last values; they are only meaningful while out_valid = 1.
- Slice arithmetic: generate g = a & b', propagate p = a ^ b' (b' = inverted b nibble).
  - Carry lookahead: c_{i+1} = g_i | (p_i & c_i), flattened per bit.
  - Sum bit i = p_i ^ c_i.
- The slice index counter is sized to hold 0..S-1 and never wraps within an operation.

Decomposition:
- Package alu_pkg:
  - typedef enum for state {IDLE, RUN, DONE}.
  - localparam NIB = 4.
  - A function computing the index width from S (clog2, minimum 1).
- One sub-module, sub4_slice: combinational 4-bit lookahead slice.
  - Ports: a[3:0], bn[3:0], cin, sum[3:0], cout.
  - Instantiated once and time-multiplexed by idx.

Test Plan:
- N=16, a=0x1234, b=0x0234 -> after 4 edges, out_valid=1, diff=0x1000, borrow=0, ovf=0, zero=0.
- a=0x0000, b=0x0001 -> diff=0xFFFF, borrow=1, ovf=0, zero=0. Also a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, ovf=1.
- a=b=0xA5A5 -> diff=0x0000, zero=1, borrow=0, ovf=0.
  - Cross-nibble borrow case: a=0x1000, b=0x0001 -> diff=0x0FFF, borrow=0, ovf=0.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> diff and flags stable, in_ready=0 throughout.
  - in_valid with new operands during RUN and DONE must not alter the result.
  - Release out_ready -> IDLE next edge, in_ready=1.
- Reset mid-RUN: assert rst after 2 slices -> next edge out_valid=0, diff=0, state IDLE.
  - Deassert rst -> in_ready=1.
  - A fresh op a=0x0005, b=0x0003 -> diff=0x0002.
- N=4 parameterisation: a=0x3, b=0x5 -> out_valid after 1 edge, diff=0xE, borrow=1, ovf=0.
